// File: rtl/video_pkg.sv
// Pixel width constants and the packed-ABGR to RGB unpacking shared by the
// video stream source and its FIFO.
package video_pkg;

    localparam int CH_W     = 8;
    localparam int RGB_W    = 3 * CH_W;
    localparam int PACKED_W = 4 * CH_W;

    // Packed word is {a, b, g, r}; the stream wants {r, g, b} and drops alpha.
    function automatic logic [RGB_W-1:0] unpack_abgr_to_rgb(input logic [PACKED_W-1:0] word);
        return {word[CH_W-1:0], word[2*CH_W-1:CH_W], word[3*CH_W-1:2*CH_W]};
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small power-of-two FIFO of RGB pixels. The caller only writes when not full
// and only reads when not empty.
module pixel_fifo #(
    parameter int DW    = 24,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/video_stream_source.sv
// Turns packed 32-bit ABGR words into a framed 24-bit RGB Avalon-ST stream,
// buffering through a small FIFO and counting pixels to mark frame edges.
module video_stream_source
    import video_pkg::*;
#(
    parameter int IDW    = 31,
    parameter int ODW    = 23,
    parameter int EW     = 1,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [IDW:0]   in_data,
    input  logic           in_data_valid,
    output logic           in_ready,
    input  logic           stream_ready,
    output logic [ODW:0]   stream_data,
    output logic           stream_startofpacket,
    output logic           stream_endofpacket,
    output logic [EW:0]    stream_empty,
    output logic           stream_valid,
    output logic           frame_done,
    output logic           overflow
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [ODW:0]  head;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          x_last;
    logic          y_last;

    // Both sides transfer on a cycle where valid and ready are high together;
    // ready never depends on valid, and a presented beat holds until taken.
    assign in_ready = !full;
    assign push     = in_data_valid && in_ready;
    assign pop      = stream_valid && stream_ready;

    pixel_fifo #(
        .DW    (ODW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (unpack_abgr_to_rgb(in_data)),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign stream_valid         = !empty;
    assign stream_data          = empty ? '0 : head;
    assign x_last               = (x == X_LAST);
    assign y_last               = (y == Y_LAST);
    assign stream_startofpacket = stream_valid && (x == '0) && (y == '0);
    assign stream_endofpacket   = stream_valid && x_last && y_last;
    assign stream_empty         = '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            x          <= '0;
            y          <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= pop && x_last && y_last;
            if (in_data_valid && !in_ready) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_video_stream_source.sv
// Scoreboard bench for video_stream_source on a 4x2 frame with a 4-deep FIFO.
module tb_video_stream_source;

    localparam int W = 4;
    localparam int H = 2;
    localparam int FRAME = W * H;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_data_valid = 1'b0;
    logic        in_ready;
    logic        stream_ready = 1'b0;
    logic [23:0] stream_data;
    logic        stream_startofpacket;
    logic        stream_endofpacket;
    logic [1:0]  stream_empty;
    logic        stream_valid;
    logic        frame_done;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;
    logic [23:0] exp_q[$];

    video_stream_source #(
        .IDW(31), .ODW(23), .EW(1), .WIDTH(W), .HEIGHT(H), .DEPTH(4)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .in_data              (in_data),
        .in_data_valid        (in_data_valid),
        .in_ready             (in_ready),
        .stream_ready         (stream_ready),
        .stream_data          (stream_data),
        .stream_startofpacket (stream_startofpacket),
        .stream_endofpacket   (stream_endofpacket),
        .stream_empty         (stream_empty),
        .stream_valid         (stream_valid),
        .frame_done           (frame_done),
        .overflow             (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] rgb_of(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        reset = 1'b0;
        in_data_valid = 1'b0;
        stream_ready = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        check("rst stream_valid", stream_valid, 0);
        check("rst stream_data", stream_data, 0);
        check("rst sop", stream_startofpacket, 0);
        check("rst eop", stream_endofpacket, 0);
        check("rst stream_empty", stream_empty, 0);
        check("rst frame_done", frame_done, 0);
        check("rst overflow", overflow, 0);
        check("rst in_ready", in_ready, 1);
    endtask

    task automatic drive_word(input logic [31:0] w, input logic [23:0] exp,
                              input logic expect_accept, input string name);
        logic acc;
        in_data = w;
        in_data_valid = 1'b1;
        acc = in_ready;
        check({name, " in_ready"}, acc, expect_accept);
        if (acc) exp_q.push_back(exp);
        @(posedge clk); #1;
        in_data_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain queue empty", exp_q.size(), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          beat_idx = 0;
    logic        eop_prev = 1'b0;
    logic        held = 1'b0;
    logic [23:0] held_data;
    logic        held_sop;
    logic        held_eop;

    always @(negedge clk) begin
        if (!reset) begin
            beat_idx = 0;
            eop_prev = 1'b0;
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall data stable", stream_data, held_data);
                check("stall sop stable", stream_startofpacket, held_sop);
                check("stall eop stable", stream_endofpacket, held_eop);
            end
            check("frame_done", frame_done, eop_prev);
            eop_prev = 1'b0;
            if (stream_valid && stream_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected beat", 1, 0);
                end else begin
                    check("beat data", stream_data, exp_q.pop_front());
                end
                check("beat sop", stream_startofpacket, (beat_idx % FRAME) == 0);
                check("beat eop", stream_endofpacket, (beat_idx % FRAME) == FRAME - 1);
                eop_prev = ((beat_idx % FRAME) == FRAME - 1);
                beat_idx++;
            end
            held = stream_valid && !stream_ready;
            held_data = stream_data;
            held_sop = stream_startofpacket;
            held_eop = stream_endofpacket;
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] frame_w [9];
    logic [23:0] frame_e [9];
    logic        rand_done = 1'b0;

    initial begin
        frame_w[0] = 32'h00102030; frame_e[0] = 24'h302010;
        frame_w[1] = 32'h11415161; frame_e[1] = 24'h615141;
        frame_w[2] = 32'h22C0FFEE; frame_e[2] = 24'hEEFFC0;
        frame_w[3] = 32'h33000000; frame_e[3] = 24'h000000;
        frame_w[4] = 32'h44FFFFFF; frame_e[4] = 24'hFFFFFF;
        frame_w[5] = 32'h55123456; frame_e[5] = 24'h563412;
        frame_w[6] = 32'h66ABCDEF; frame_e[6] = 24'hEFCDAB;
        frame_w[7] = 32'h77808182; frame_e[7] = 24'h828180;
        frame_w[8] = 32'h88010203; frame_e[8] = 24'h030201;

        @(posedge clk); #1;
        apply_reset();

        // First pixel appears the cycle after its push, framed as sop.
        stream_ready = 1'b1;
        drive_word(32'hFF112233, 24'h332211, 1, "first push");
        check("first valid", stream_valid, 1);
        check("first data", stream_data, 24'h332211);
        check("first sop", stream_startofpacket, 1);
        check("first eop", stream_endofpacket, 0);
        wait_drain(20);

        // Continuous frame plus the first beat of the next one.
        apply_reset();
        stream_ready = 1'b1;
        for (int i = 0; i < 9; i++) drive_word(frame_w[i], frame_e[i], 1, "frame push");
        wait_drain(20);

        // Backpressure: fill, overflow, then simultaneous push/pop on full.
        apply_reset();
        for (int i = 0; i < 4; i++) drive_word(frame_w[i], frame_e[i], 1, "fill push");
        check("full in_ready", in_ready, 0);
        drive_word(32'hDEADBEEF, 24'h0, 0, "overflow push");
        check("overflow set", overflow, 1);
        stream_ready = 1'b1;
        drive_word(32'hCAFEF00D, 24'h0, 0, "full push+pop");
        check("count 3 in_ready", in_ready, 1);
        check("overflow sticky", overflow, 1);
        wait_drain(20);

        // Random backpressure across three frames.
        apply_reset();
        fork
            begin
                for (int i = 0; i < 3 * FRAME; i++) begin
                    logic [31:0] w;
                    int t;
                    w = {8'(i), 8'(8'h40 + i), 8'(8'h80 + i), 8'(8'hC0 + i)};
                    t = 0;
                    while (!in_ready && t < 100) begin
                        @(posedge clk); #1;
                        t++;
                    end
                    drive_word(w, rgb_of(w), 1, "rand push");
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    stream_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        stream_ready = 1'b1;
        wait_drain(50);

        // Reset mid-frame with pixels still buffered.
        apply_reset();
        stream_ready = 1'b1;
        for (int i = 0; i < 5; i++) drive_word(frame_w[i], frame_e[i], 1, "mid push");
        @(posedge clk); #1;
        stream_ready = 1'b0;
        drive_word(frame_w[5], frame_e[5], 1, "mid buffered");
        drive_word(frame_w[6], frame_e[6], 1, "mid buffered");
        check("mid eop idx", beat_idx, 5);
        apply_reset();
        stream_ready = 1'b1;
        drive_word(frame_w[8], frame_e[8], 1, "post reset push");
        check("post reset sop", stream_startofpacket, 1);
        check("post reset data", stream_data, frame_e[8]);
        wait_drain(20);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_stream_source.md
# video_stream_source

Converts 32-bit packed pixel words ({alpha, blue, green, red}, 8 bits each) from the processor/memory side into a 24-bit RGB Avalon-ST video stream for the video output pipeline, i.e. the opposite direction of the input-side 24-to-32 packer. Buffers pixels in a small FIFO, honours downstream backpressure, and generates start/end-of-packet framing from internal column/row counters for a fixed frame size.

## Interface
- IDW, 31, input word width minus 1 (32-bit packed pixel)
- ODW, 23, stream data width minus 1 (24-bit RGB)
- EW, 1, stream_empty width minus 1
- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- DEPTH, 4, FIFO entries (power of two, ≥2)

- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- in_data  input  IDW+1  packed pixel {a[31:24], b[23:16], g[15:8], r[7:0]}
- in_data_valid  input  1  in_data valid this cycle
- in_ready  output  1  FIFO can accept a word this cycle
- stream_ready  input  1  downstream accepts a beat
- stream_data  output  ODW+1  {r, g, b}
- stream_startofpacket  output  1  first pixel of frame
- stream_endofpacket  output  1  last pixel of frame
- stream_empty  output  EW+1  constant 0
- stream_valid  output  1  beat valid
- frame_done  output  1  one-cycle pulse after last beat of a frame accepted
- overflow  output  1  sticky: write attempted while in_ready low

## Operation
- Push: in_data_valid && in_ready; FIFO stores {r,g,b} = {in_data[7:0], in_data[15:8], in_data[23:16]}; alpha discarded.
- Pop: stream_valid && stream_ready; head advances.
- stream_valid = FIFO non-empty; stream_data = head entry.
- Counters x ∈ [0,WIDTH-1], y ∈ [0,HEIGHT-1] advance only on pop; x wraps to 0 and y increments at WIDTH-1; y wraps to 0 at HEIGHT-1 end of line.
- stream_startofpacket = stream_valid && x==0 && y==0; stream_endofpacket = stream_valid && x==WIDTH-1 && y==HEIGHT-1.
- in_ready = count < DEPTH (derived from registered count; a same-cycle pop does not open a slot).
- Count: +1 push only, −1 pop only, unchanged on simultaneous push/pop.
- in_data_valid while in_ready low: word dropped, overflow set until reset; FIFO unchanged.
- frame_done registered: asserts the cycle after the pop that carried endofpacket.
- Counter widths: $clog2(WIDTH), $clog2(HEIGHT); no arithmetic beyond increment/compare.

## Timing
- Reset (reset==0 at a clock edge): FIFO emptied, count=0, x=y=0, stream_valid=0, stream_data=0, sop=eop=0, stream_empty=0, frame_done=0, overflow=0, in_ready=1 from next cycle.
- Latency: word pushed at edge N is presented on stream_valid after edge N (visible cycle N+1) when FIFO was empty.
- Throughput: one pixel per clock with stream_ready held high and continuous input.
- Held beats: while stream_valid && !stream_ready, stream_data, sop, eop stable.
- Reset mid-frame: buffered pixels discarded, next accepted pixel carries startofpacket.

## Structure
- Shared package video_pkg: pixel width constants (8-bit channel, 24-bit RGB, 32-bit packed), function unpack_abgr_to_rgb.
- Sub-module pixel_fifo (DEPTH × 24 bits, wr/rd pointers, count, full/empty) instantiated once; framing counters and flags in top.

## Test plan (WIDTH=4, HEIGHT=2, DEPTH=4)
- Reset then push 0xFF112233 with stream_ready=1 -> next cycle stream_valid=1, stream_data=0x332211, startofpacket=1, endofpacket=0.
- Stream 8 words continuously, stream_ready=1 -> sop on beat 0 only, eop on beat 7 only, frame_done pulses cycle after beat 7, beat 8 carries sop again.
- stream_ready=0, push 4 words -> in_ready=0 after 4th; 5th push sets overflow=1; release ready -> exactly the 4 original words emerge in order.
- Full FIFO, simultaneous push and pop -> push rejected, overflow=1, count 3 after.
- Random stream_ready toggling over 3 frames -> data order preserved, sop/eop at indices 0/7 mod 8, outputs stable while stalled.
- Assert reset (low) after 5 beats -> all outputs 0 next cycle, next frame sop on first beat.
